// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate cache between a 32-bit CPU
// load/store port and line-wide main memory. Blocking: one CPU request in flight.
// Tree-PLRU replacement, byte-enable stores, request/response handshakes on both sides.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cpu_req_*                  CPU request: addr, valid, wr (1=store), be, cpu_wr_data
//   cpu_req_ready              high only in IDLE, and only from the first edge after reset release
//   cpu_resp_valid/rd_data     one-cycle completion pulse; rd_data updated on loads only
//   mem_req_*                  line request: addr (line aligned), valid, wr (1=write-back),
//                              mem_wr_data (victim line); mem_req_ready completes it
//   mem_rd_data                fill line, sampled on mem_req_ready during ALLOCATE
//   stats_clr, hit_cnt,        only when CACHE_STATS_EN is defined: saturating hit/miss/
//   miss_cnt, wb_cnt           write-back counters, synchronous clear
//
// Build option: `define CACHE_STATS_EN to add the statistics counters and their ports.
module assoc_cache #(
   parameter int unsigned WAYS      = 2,
   parameter int unsigned SETS      = 16,
   parameter int unsigned LINE_BITS = 128,
   parameter int unsigned ADDR_BITS = 17
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef CACHE_STATS_EN
   input  logic                 stats_clr,
   output logic [31:0]          hit_cnt,
   output logic [31:0]          miss_cnt,
   output logic [31:0]          wb_cnt,
`endif
   input  logic [ADDR_BITS-1:0] cpu_req_addr,
   input  logic                 cpu_req_valid,
   input  logic                 cpu_req_wr,
   input  logic [3:0]           cpu_req_be,
   input  logic [31:0]          cpu_wr_data,
   output logic                 cpu_req_ready,
   output logic                 cpu_resp_valid,
   output logic [31:0]          cpu_rd_data,
   output logic [ADDR_BITS-1:0] mem_req_addr,
   output logic                 mem_req_valid,
   output logic                 mem_req_wr,
   output logic [LINE_BITS-1:0] mem_wr_data,
   input  logic [LINE_BITS-1:0] mem_rd_data,
   input  logic                 mem_req_ready
);
   localparam int unsigned OFF = $clog2(LINE_BITS / 8);
   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned TAG = ADDR_BITS - IDX - OFF;
   localparam int unsigned WW  = $clog2(WAYS);
   localparam int unsigned WSEL = OFF - 2;

   typedef enum logic [1:0] {StIdle, StLookup, StWriteBack, StAllocate} state_e;
   state_e state_q, state_d;

   // Tag/data arrays are not reset; valid, dirty and PLRU state are.
   logic [TAG-1:0]            tag_mem  [SETS][WAYS];
   logic [LINE_BITS-1:0]      data_mem [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
   // PLRU tree as a 1-based heap: node n has children 2n, 2n+1; bit 0 is never used.
   logic [SETS-1:0][WAYS-1:0] plru_q;

   logic [ADDR_BITS-1:0] req_addr_q;
   logic                 req_wr_q;
   logic [3:0]           req_be_q;
   logic [31:0]          req_data_q;
   logic                 fill_q;       // current LOOKUP follows a fill
   logic [WW-1:0]        victim_q;
   logic                 mem_valid_q;
   logic                 init_q;       // first edge after reset release seen
   logic                 resp_valid_q;
   logic [31:0]          rd_data_q;

   logic [IDX-1:0]       idx;
   logic [TAG-1:0]       tag;
   logic [WSEL-1:0]      word;
   logic                 hit, inv_found, accept, wb_done, fill_done;
   logic [WW-1:0]        hit_way, inv_way, plru_way, victim;
   logic [WAYS-1:0]      plru_upd;
   logic [LINE_BITS-1:0] merged, be_mask;
   logic [31:0]          rd_word;
   logic                 unused_addr_lsb;

   assign unused_addr_lsb = ^cpu_req_addr[1:0];
   assign idx  = req_addr_q[OFF +: IDX];
   assign tag  = req_addr_q[OFF + IDX +: TAG];
   assign word = req_addr_q[2 +: WSEL];

   assign accept    = (state_q == StIdle) && cpu_req_valid && init_q;
   assign wb_done   = (state_q == StWriteBack) && mem_valid_q && mem_req_ready;
   assign fill_done = (state_q == StAllocate) && mem_valid_q && mem_req_ready;

   // Tag compare and lowest-index invalid way (loop runs high to low so the lowest wins).
   always_comb begin
      logic [WW-1:0] wi;
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         wi = WW'(w);
         if (valid_q[idx][wi] && tag_mem[idx][wi] == tag) begin
            hit     = 1'b1;
            hit_way = wi;
         end
         if (!valid_q[idx][wi]) begin
            inv_found = 1'b1;
            inv_way   = wi;
         end
      end
   end

   // PLRU walk: each bit names the subtree holding the victim (0=left/lower ways).
   always_comb begin
      int node;
      int hw;
      int d;
      node = 1;
      for (int l = 0; l < int'(WW); l++) begin
         node = 2 * node + int'(plru_q[idx][WW'(node)]);
      end
      plru_way = WW'(node - int'(WAYS));
      // On a hit, point every node on the path away from the hit way.
      plru_upd = plru_q[idx];
      hw       = int'(hit_way);
      node     = 1;
      for (int l = 0; l < int'(WW); l++) begin
         d = (hw >> (int'(WW) - 1 - l)) & 1;
         plru_upd[WW'(node)] = (d == 0);
         node = 2 * node + d;
      end
   end

   assign victim = inv_found ? inv_way : plru_way;

   // Word read and byte-enable merge for the hit way.
   always_comb begin
      be_mask = '0;
      for (int b = 0; b < 4; b++) begin
         if (((req_be_q >> b) & 4'd1) != 4'd0) begin
            be_mask = be_mask | (LINE_BITS'(32'hFF << (8 * b)) << (32 * int'(word)));
         end
      end
      merged  = (data_mem[idx][hit_way] & ~be_mask)
              | ((LINE_BITS'(req_data_q) << (32 * int'(word))) & be_mask);
      rd_word = 32'(data_mem[idx][hit_way] >> (32 * int'(word)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      cpu_req_ready = (state_q == StIdle) && init_q;
      mem_req_valid = mem_valid_q;
      mem_req_wr    = mem_valid_q && (state_q == StWriteBack);
      mem_req_addr  = '0;
      mem_wr_data   = '0;
      if (mem_valid_q) begin
         if (state_q == StWriteBack) begin
            mem_req_addr = {tag_mem[idx][victim_q], idx, {OFF{1'b0}}};
            mem_wr_data  = data_mem[idx][victim_q];
         end else begin
            mem_req_addr = {tag, idx, {OFF{1'b0}}};
         end
      end
      unique case (state_q)
         StIdle:      if (accept) state_d = StLookup;
         StLookup: begin
            if (hit)                                             state_d = StIdle;
            else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = StWriteBack;
            else                                                 state_d = StAllocate;
         end
         StWriteBack: if (wb_done) state_d = StAllocate;
         StAllocate:  if (fill_done) state_d = StLookup;
         default:     state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[idx][victim_q] <= mem_rd_data;
         tag_mem[idx][victim_q]  <= tag;
      end else if (state_q == StLookup && hit && req_wr_q) begin
         data_mem[idx][hit_way] <= merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q       <= 1'b0;
         req_addr_q   <= '0;
         req_wr_q     <= 1'b0;
         req_be_q     <= '0;
         req_data_q   <= '0;
         fill_q       <= 1'b0;
         victim_q     <= '0;
         mem_valid_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         rd_data_q    <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         plru_q       <= '0;
      end else begin
         init_q       <= 1'b1;
         resp_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  req_addr_q <= cpu_req_addr;
                  req_wr_q   <= cpu_req_wr;
                  req_be_q   <= cpu_req_be;
                  req_data_q <= cpu_wr_data;
                  fill_q     <= 1'b0;
               end
            end
            StLookup: begin
               if (hit) begin
                  resp_valid_q <= 1'b1;
                  plru_q[idx]  <= plru_upd;
                  if (req_wr_q) dirty_q[idx][hit_way] <= 1'b1;
                  else          rd_data_q <= rd_word;
               end else begin
                  victim_q    <= victim;
                  mem_valid_q <= 1'b1;
               end
            end
            // Dropping valid after a completed write-back leaves one idle cycle before the fill.
            StWriteBack: if (wb_done) mem_valid_q <= 1'b0;
            StAllocate: begin
               if (!mem_valid_q) begin
                  mem_valid_q <= 1'b1;
               end else if (mem_req_ready) begin
                  mem_valid_q               <= 1'b0;
                  valid_q[idx][victim_q]    <= 1'b1;
                  dirty_q[idx][victim_q]    <= 1'b0;
                  fill_q                    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu_resp_valid = resp_valid_q;
   assign cpu_rd_data    = rd_data_q;

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else if (stats_clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else begin
         if (state_q == StLookup && hit && !fill_q && hit_cnt != 32'hFFFF_FFFF)
            hit_cnt <= hit_cnt + 32'd1;
         if (state_q == StLookup && !hit && miss_cnt != 32'hFFFF_FFFF)
            miss_cnt <= miss_cnt + 32'd1;
         if (wb_done && wb_cnt != 32'hFFFF_FFFF)
            wb_cnt <= wb_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [16:0]  cpu_req_addr = '0;
   logic         cpu_req_valid = 1'b0;
   logic         cpu_req_wr = 1'b0;
   logic [3:0]   cpu_req_be = '0;
   logic [31:0]  cpu_wr_data = '0;
   logic         cpu_req_ready, cpu_resp_valid;
   logic [31:0]  cpu_rd_data;
   logic [16:0]  mem_req_addr;
   logic         mem_req_valid, mem_req_wr;
   logic [127:0] mem_wr_data;
   logic [127:0] mem_rd_data = '0;
   logic         mem_req_ready = 1'b0;
`ifdef CACHE_STATS_EN
   logic         stats_clr = 1'b0;
   logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

   assoc_cache dut (
      .clk(clk), .rst_n(rst_n),
`ifdef CACHE_STATS_EN
      .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
`endif
      .cpu_req_addr(cpu_req_addr), .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr),
      .cpu_req_be(cpu_req_be), .cpu_wr_data(cpu_wr_data), .cpu_req_ready(cpu_req_ready),
      .cpu_resp_valid(cpu_resp_valid), .cpu_rd_data(cpu_rd_data),
      .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_req_ready(mem_req_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   // Reference: flat word memory (golden CPU view) plus a line memory seen by the cache.
   logic [31:0]  gold      [int];
   logic [127:0] mem_lines [int];
   logic         mem_stall = 1'b0;
   int n_fill = 0, n_wb = 0, ev_seq = 0, fill_seq = 0, wb_seq = 0;
   int last_fill_addr = -1, last_wb_addr = -1;
   logic [127:0] last_wb_data = '0;

   function automatic logic [31:0] init_word(input int a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h5BD1E995;
   endfunction

   function automatic logic [31:0] gold_word(input int a);
      int k = a & ~3;
      if (gold.exists(k)) return gold[k];
      return init_word(k);
   endfunction

   function automatic logic [127:0] gold_line(input int a);
      logic [127:0] l = '0;
      for (int i = 0; i < 4; i++) l = l | (128'(gold_word((a & ~15) + 4 * i)) << (32 * i));
      return l;
   endfunction

   function automatic logic [127:0] mem_line(input int a);
      logic [127:0] l = '0;
      if (mem_lines.exists(a)) return mem_lines[a];
      for (int i = 0; i < 4; i++) l = l | (128'(init_word(a + 4 * i)) << (32 * i));
      return l;
   endfunction

   // Memory responder: random 0..3 cycle latency, ready driven on the falling edge.
   int rsp_wait = 0, rsp_lat = 1;
   initial begin
      forever begin
         @(negedge clk);
         mem_req_ready = 1'b0;
         if (mem_req_valid && !mem_stall && rst_n) begin
            if (rsp_wait < rsp_lat) rsp_wait++;
            else begin
               rsp_wait = 0;
               rsp_lat = int'($urandom_range(0, 3));
               mem_req_ready = 1'b1;
               ev_seq++;
               if (mem_req_wr) begin
                  mem_lines[int'(mem_req_addr)] = mem_wr_data;
                  n_wb++; wb_seq = ev_seq;
                  last_wb_addr = int'(mem_req_addr); last_wb_data = mem_wr_data;
               end else begin
                  mem_rd_data = mem_line(int'(mem_req_addr));
                  n_fill++; fill_seq = ev_seq; last_fill_addr = int'(mem_req_addr);
               end
            end
         end
      end
   end

   // Called on a falling edge; returns on the falling edge after the accepting edge.
   task automatic cpu_issue(input logic wr, input int addr, input logic [3:0] be,
                            input logic [31:0] data);
      int guard = 0;
      logic [31:0] v;
      while (!cpu_req_ready && guard < 300) begin @(negedge clk); guard++; end
      if (!cpu_req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout addr=%h ready=%b required 1", addr, cpu_req_ready);
      end
      cpu_req_valid = 1'b1; cpu_req_wr = wr; cpu_req_addr = 17'(addr);
      cpu_req_be = be; cpu_wr_data = data;
      if (wr) begin
         v = gold_word(addr);
         for (int b = 0; b < 4; b++)
            if (((be >> b) & 4'd1) != 4'd0)
               v = (v & ~(32'hFF << (8 * b))) | (data & (32'hFF << (8 * b)));
         gold[addr & ~3] = v;
      end
      @(posedge clk);
      @(negedge clk);
      cpu_req_valid = 1'b0;
   endtask

   // lat counts falling edges since the accepting edge: 2 for a hit.
   task automatic cpu_wait(output logic [31:0] rd, output int lat);
      lat = 1;
      while (!cpu_resp_valid && lat < 300) begin @(negedge clk); lat++; end
      if (!cpu_resp_valid) begin
         n_checks++; n_fail++;
         $display("FAIL resp_timeout resp_valid=%b required 1", cpu_resp_valid);
      end
      rd = cpu_rd_data;
   endtask

   task automatic cpu_access(input logic wr, input int addr, input logic [3:0] be,
                             input logic [31:0] data, output logic [31:0] rd, output int lat);
      cpu_issue(wr, addr, be, data);
      cpu_wait(rd, lat);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cpu_req_ready, cpu_resp_valid, cpu_rd_data, mem_req_valid, mem_req_wr, mem_req_addr,
           mem_wr_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs ready=%b resp=%b rd=%h mvalid=%b maddr=%h required all 0",
                  cpu_req_ready, cpu_resp_valid, cpu_rd_data, mem_req_valid, mem_req_addr);
      end
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (cpu_req_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_reset got=%b required 1", cpu_req_ready);
      end
   endtask

   task automatic test_cold_load();
      logic [31:0] rd; int lat, f0, w0;
      gold[32'h44] = 32'hDEADBEEF;
      gold[32'h48] = 32'hAAAAAAAA;
      mem_lines[32'h40] = gold_line(32'h40);
      f0 = n_fill; w0 = n_wb;
      cpu_access(1'b0, 32'h44, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (n_fill != f0 + 1 || last_fill_addr != 32'h40 || n_wb != w0) begin
         n_fail++; $display("FAIL cold_fill fills=%0d addr=%h wbs=%0d required 1 at 00040, 0 wb",
                            n_fill - f0, last_fill_addr, n_wb - w0);
      end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cold_data got=%h required deadbeef", rd); end
      f0 = n_fill;
      cpu_access(1'b0, 32'h44, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (lat != 2 || n_fill != f0 || rd !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL reload_hit lat=%0d fills=%0d rd=%h required 2, 0, deadbeef",
                            lat, n_fill - f0, rd);
      end
   endtask

   task automatic test_store_merge();
      logic [31:0] rd; int lat;
      cpu_access(1'b1, 32'h48, 4'b0011, 32'h12345678, rd, lat);
      n_checks++;
      if (lat != 2 || rd !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL store_hit lat=%0d rd=%h required 2 and held deadbeef", lat, rd);
      end
      cpu_access(1'b0, 32'h48, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (rd !== 32'hAAAA5678 || lat != 2) begin
         n_fail++; $display("FAIL store_merge rd=%h lat=%0d required aaaa5678, 2", rd, lat);
      end
   endtask

   task automatic test_write_back();
      logic [31:0] rd; int lat, w0, f0; logic [127:0] exp_wb;
      exp_wb = gold_line(32'h40);
      w0 = n_wb; f0 = n_fill;
      cpu_access(1'b0, 32'h140, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (n_wb != w0 || last_fill_addr != 32'h140 || rd !== gold_word(32'h140)) begin
         n_fail++; $display("FAIL second_way wbs=%0d fill=%h rd=%h required 0, 00140, %h",
                            n_wb - w0, last_fill_addr, rd, gold_word(32'h140));
      end
      cpu_access(1'b0, 32'h140, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL second_way_hit lat=%0d required 2", lat); end
      cpu_access(1'b0, 32'h240, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (n_wb != w0 + 1 || last_wb_addr != 32'h40 || last_wb_data !== exp_wb) begin
         n_fail++; $display("FAIL wb_line wbs=%0d addr=%h data=%h required 1, 00040, %h",
                            n_wb - w0, last_wb_addr, last_wb_data, exp_wb);
      end
      n_checks++;
      if (32'(last_wb_data >> 64) !== 32'hAAAA5678) begin
         n_fail++; $display("FAIL wb_word2 got=%h required aaaa5678", 32'(last_wb_data >> 64));
      end
      n_checks++;
      if (last_fill_addr != 32'h240 || fill_seq <= wb_seq || rd !== gold_word(32'h240)) begin
         n_fail++; $display("FAIL wb_then_fill fill=%h order=%0d/%0d rd=%h required 00240 after wb",
                            last_fill_addr, wb_seq, fill_seq, rd);
      end
      f0 = n_fill;
      cpu_access(1'b0, 32'h140, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (lat != 2 || n_fill != f0) begin
         n_fail++; $display("FAIL survivor_hit lat=%0d fills=%0d required 2, 0", lat, n_fill - f0);
      end
   endtask

`ifdef CACHE_STATS_EN
   task automatic test_stats();
      n_checks++;
      if (hit_cnt !== 32'd5 || miss_cnt !== 32'd3 || wb_cnt !== 32'd1) begin
         n_fail++; $display("FAIL stats hit=%0d miss=%0d wb=%0d required 5 3 1",
                            hit_cnt, miss_cnt, wb_cnt);
      end
      stats_clr = 1'b1; @(posedge clk); @(negedge clk); stats_clr = 1'b0;
      n_checks++;
      if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin
         n_fail++; $display("FAIL stats_clr hit=%0d miss=%0d wb=%0d required 0",
                            hit_cnt, miss_cnt, wb_cnt);
      end
   endtask
`endif

   task automatic test_wb_stall();
      logic [31:0] rd; int lat, guard; logic [127:0] exp_line;
      cpu_access(1'b1, 32'h240, 4'hF, 32'h0BADF00D, rd, lat);
      cpu_access(1'b0, 32'h140, 4'h0, 32'h0, rd, lat);
      exp_line = gold_line(32'h240);
      mem_stall = 1'b1;
      cpu_issue(1'b0, 32'h344, 4'h0, 32'h0);
      guard = 0;
      while (!mem_req_valid && guard < 20) begin @(negedge clk); guard++; end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data, cpu_req_ready} !==
             {1'b1, 1'b1, 17'h00240, exp_line, 1'b0}) begin
            n_fail++; $display("FAIL wb_stall cyc%0d v=%b wr=%b a=%h d=%h rdy=%b required 1 1 00240 %h 0",
                               i, mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
                               cpu_req_ready, exp_line);
         end
         @(negedge clk);
      end
      mem_stall = 1'b0;
      cpu_wait(rd, lat);
      n_checks++;
      if (rd !== gold_word(32'h344) || last_fill_addr != 32'h340 || last_wb_addr != 32'h240) begin
         n_fail++; $display("FAIL after_stall rd=%h fill=%h wb=%h required %h 00340 00240",
                            rd, last_fill_addr, last_wb_addr, gold_word(32'h344));
      end
   endtask

   task automatic test_reset_in_alloc();
      logic [31:0] rd; int lat, guard, f0;
      mem_stall = 1'b1;
      cpu_issue(1'b0, 32'h544, 4'h0, 32'h0);
      guard = 0;
      while (!mem_req_valid && guard < 20) begin @(negedge clk); guard++; end
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_wr !== 1'b0 || mem_req_addr !== 17'h00540) begin
         n_fail++; $display("FAIL alloc_req v=%b wr=%b a=%h required 1 0 00540",
                            mem_req_valid, mem_req_wr, mem_req_addr);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_req_valid, cpu_req_ready, cpu_resp_valid, mem_req_addr} !== '0) begin
         n_fail++; $display("FAIL reset_drop v=%b rdy=%b resp=%b a=%h required 0",
                            mem_req_valid, cpu_req_ready, cpu_resp_valid, mem_req_addr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1; mem_stall = 1'b0;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (cpu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset rdy=%b v=%b required 1 0", cpu_req_ready, mem_req_valid);
      end
      f0 = n_fill;
      cpu_access(1'b0, 32'h44, 4'h0, 32'h0, rd, lat);
      n_checks++;
      if (n_fill != f0 + 1 || last_fill_addr != 32'h40 || lat <= 2 || rd !== gold_word(32'h44)) begin
         n_fail++; $display("FAIL miss_after_reset fills=%0d a=%h lat=%0d rd=%h required 1 00040 >2 %h",
                            n_fill - f0, last_fill_addr, lat, rd, gold_word(32'h44));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd1, rd2; int lat1, lat2, c0, c1; logic rdy;
      c0 = cyc;
      cpu_access(1'b0, 32'h44, 4'h0, 32'h0, rd1, lat1);
      rdy = cpu_req_ready;
      cpu_access(1'b0, 32'h48, 4'h0, 32'h0, rd2, lat2);
      c1 = cyc;
      n_checks++;
      if (lat1 != 2 || lat2 != 2 || rdy !== 1'b1 || c1 - c0 != 4) begin
         n_fail++; $display("FAIL back_to_back lat=%0d/%0d rdy=%b cycles=%0d required 2/2 1 4",
                            lat1, lat2, rdy, c1 - c0);
      end
      n_checks++;
      if (rd1 !== gold_word(32'h44) || rd2 !== gold_word(32'h48)) begin
         n_fail++; $display("FAIL back_to_back_data %h %h required %h %h",
                            rd1, rd2, gold_word(32'h44), gold_word(32'h48));
      end
   endtask

   // Random loads/stores on 6 tags x 4 sets to force evictions; loads checked against gold.
   task automatic test_random();
      logic [31:0] rd, exp, data; int lat, addr; logic wr; logic [3:0] be;
      for (int i = 0; i < 200; i++) begin
         addr = (int'($urandom_range(0, 5)) << 8) | (int'($urandom_range(0, 3)) << 4)
              | (int'($urandom_range(0, 3)) << 2) | int'($urandom_range(0, 3));
         wr   = 1'($urandom_range(0, 1));
         be   = 4'($urandom);
         data = $urandom;
         exp  = gold_word(addr);
         cpu_access(wr, addr, be, data, rd, lat);
         if (!wr) begin
            n_checks++;
            if (rd !== exp) begin
               n_fail++; $display("FAIL rand_load #%0d addr=%h got=%h required %h", i, addr, rd, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_store_merge();
      test_write_back();
`ifdef CACHE_STATS_EN
      test_stats();
`endif
      test_wb_stall();
      test_reset_in_alloc();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout time=%0t required finish earlier", $time);
      $fatal(1, "timeout");
   end
endmodule
